// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and helpers for the multi-channel DAC sequencer
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    localparam int HDR_W = 8;

    function automatic int frame_bits(input int data_w);
        return HDR_W + data_w;
    endfunction

    // Channel number sits in header bits [4:1]
    function automatic logic [HDR_W-1:0] make_header(input logic [HDR_W-1:0] cmd_base,
                                                     input logic [3:0]       ch);
        return cmd_base | {3'b000, ch, 1'b0};
    endfunction

endpackage

// File: rtl/sine_lut.sv
// rtl/sine_lut.sv - offset-binary sine ROM, synchronous read, one-cycle latency
module sine_lut #(
    parameter int LUT_AW = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DATA_W-1:0] q
);

    localparam int  DEPTH = 1 << LUT_AW;
    localparam real PI    = 3.141592653589793;

    // Floor rather than round-to-nearest: reproduces the reference table (entry 1 = 8C8B)
    function automatic logic [DATA_W-1:0] lut_val(input int n);
        real half;
        real v;
        half = 2.0 ** (DATA_W - 1);
        v = $floor(half + half * $sin(2.0 * PI * real'(n) / real'(DEPTH)));
        if (v > 2.0 * half - 1.0) v = 2.0 * half - 1.0;
        if (v < 0.0) v = 0.0;
        return DATA_W'($rtoi(v));
    endfunction

    logic [DATA_W-1:0] rom [DEPTH];

    for (genvar n = 0; n < DEPTH; n++) begin : g_rom
        assign rom[n] = lut_val(n);
    end

    always_ff @(posedge clk) begin
        q <= rom[addr];
    end

endmodule

// File: rtl/dac_multich_seq.sv
// rtl/dac_multich_seq.sv - round-robin serial DAC frame sequencer with per-channel phase
module dac_multich_seq
    import dac_pkg::*;
#(
    parameter int         NUM_CH     = 4,
    parameter int         DATA_W     = 16,
    parameter int         LUT_AW     = 6,
    parameter int         PHASE_STEP = 16,
    parameter logic [7:0] CMD_BASE   = 8'h10,
    parameter int         CLK_DIV    = 1,
    parameter int         SYNC_GAP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [LUT_AW-1:0] cfg_phase,
    output logic              sync,
    output logic              sclk,
    output logic              din,
    output logic              busy,
    output logic              frame_done,
    output logic              trig_overrun,
    output logic [3:0]        cur_ch
);

    localparam int FRAME_W = frame_bits(DATA_W);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int GAP_W   = $clog2(SYNC_GAP + 1);

    state_t            state;
    logic              trig_q;
    logic              load_wait;
    logic [CH_W-1:0]   next_ch;
    logic [LUT_AW-1:0] phase [NUM_CH];
    logic [LUT_AW-1:0] lut_addr;
    logic [DATA_W-1:0] lut_q;
    logic [FRAME_W-2:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic               trig_edge;
    logic               cfg_hit;
    logic [CH_W-1:0]    ch_idx;
    logic [FRAME_W-1:0] frame_word;

    assign trig_edge  = trigger & ~trig_q;
    assign cfg_hit    = cfg_we && ({1'b0, cfg_ch} < 5'(NUM_CH));
    assign ch_idx     = cur_ch[CH_W-1:0];
    assign frame_word = {make_header(CMD_BASE, cur_ch), lut_q};

    sine_lut #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .q    (lut_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            trig_q       <= 1'b0;
            load_wait    <= 1'b0;
            next_ch      <= '0;
            lut_addr     <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            sync         <= 1'b1;
            sclk         <= 1'b1;
            din          <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            trig_overrun <= 1'b0;
            cur_ch       <= '0;
            for (int i = 0; i < NUM_CH; i++) phase[i] <= '0;
        end else begin
            trig_q       <= trigger;
            frame_done   <= 1'b0;
            trig_overrun <= trig_edge && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (trig_edge) begin
                        busy      <= 1'b1;
                        cur_ch    <= 4'(next_ch);
                        lut_addr  <= phase[next_ch];
                        load_wait <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                // First LOAD cycle waits for the registered ROM read
                ST_LOAD: begin
                    load_wait <= 1'b0;
                    if (!load_wait) begin
                        sync    <= 1'b0;
                        sclk    <= 1'b1;
                        din     <= frame_word[FRAME_W-1];
                        shreg   <= frame_word[FRAME_W-2:0];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt != DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (sclk) begin
                            sclk <= 1'b0;
                        end else if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                            sync          <= 1'b1;
                            sclk          <= 1'b1;
                            din           <= 1'b1;
                            frame_done    <= 1'b1;
                            phase[ch_idx] <= phase[ch_idx] + LUT_AW'(PHASE_STEP);
                            next_ch       <= (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + CH_W'(1);
                            gap_cnt       <= '0;
                            state         <= ST_GAP;
                        end else begin
                            sclk    <= 1'b1;
                            din     <= shreg[FRAME_W-2];
                            shreg   <= {shreg[FRAME_W-3:0], 1'b1};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(SYNC_GAP - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Placed last so a host write beats the end-of-frame advance
            if (cfg_hit) phase[cfg_ch[CH_W-1:0]] <= cfg_phase;
        end
    end

endmodule
